// File: rtl/console_key_injector.sv
// console_key_injector
//
// Buffers command bytes from the command-file reader in a small FIFO and
// replays them into the console receive path as single-cycle key strobes.
// Each strobe waits for the console to be ready and is followed by a fixed
// idle gap. Nothing is drained until machine time reaches the boot threshold.
//
// Parameters:
//   DEPTH       FIFO entries (power of two, >= 2)
//   GAP_CYCLES  idle cycles after every key strobe (0 allowed)
//   CNT_W       width of the dropped-byte counter
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   i_wr, i_data     byte write from the command-file reader
//   i_flush          discard buffered bytes and abort any injection
//   i_consf_en       console busy (0 = console can take a key)
//   i_mtime          machine time
//   i_min_time       boot-complete threshold
//   o_we, o_key      registered one-cycle key strobe and key byte
//   o_full, o_level  registered FIFO full flag and occupancy
//   o_busy           FIFO not empty or injection in progress
//   o_ovf            sticky overflow flag
//   o_drop_cnt       saturating count of bytes dropped while full

module console_key_injector #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP_CYCLES = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr,
  input  logic [7:0]               i_data,
  input  logic                     i_flush,
  input  logic                     i_consf_en,
  input  logic [63:0]              i_mtime,
  input  logic [63:0]              i_min_time,
  output logic                     o_we,
  output logic [7:0]               o_key,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_busy,
  output logic                     o_ovf,
  output logic [CNT_W-1:0]         o_drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW:0] DepthL = (AW + 1)'(DEPTH);
  localparam logic [GW-1:0] GapLoad = GW'(GAP_CYCLES - 1);
  localparam bit GapZero = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {
    StIdle,
    StWaitRdy,
    StSend,
    StGap
  } state_e;

  state_e state_q, state_d;

  logic [GW-1:0]    gap_q, gap_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             we_q, we_d;
  logic [7:0]       key_q, key_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             boot_done_q, boot_done_d;

  logic [7:0] mem_q [DEPTH];

  logic empty;
  logic pop;
  logic wr_ok;
  logic drop;

  assign empty = (level_q == '0);

  // Fullness is the registered value, so a write landing in a pop cycle while
  // full is still dropped. Flush swallows any same-cycle write silently.
  assign wr_ok = i_wr && !full_q && !i_flush;
  assign drop  = i_wr &&  full_q && !i_flush;

  // Injection FSM
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (boot_done_q && !empty) state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (!i_consf_en) state_d = StSend;
      end
      StSend: begin
        pop = 1'b1;
        if (GapZero) begin
          state_d = StIdle;
        end else begin
          state_d = StGap;
          gap_d   = GapLoad;
        end
      end
      StGap: begin
        if (gap_q == '0) state_d = StIdle;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = StIdle;
    endcase
    if (i_flush) begin
      state_d = StIdle;
      gap_d   = '0;
      pop     = 1'b0;
    end
  end

  // FIFO bookkeeping, strobe outputs and status
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    key_d       = key_q;
    we_d        = pop;
    ovf_d       = ovf_q | drop;
    drop_cnt_d  = drop_cnt_q;
    boot_done_d = boot_done_q | (i_mtime >= i_min_time);

    if (wr_ok) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
      key_d    = mem_q[rd_ptr_q[AW-1:0]];
    end

    unique case ({wr_ok, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    if (drop && (drop_cnt_q != {CNT_W{1'b1}})) drop_cnt_d = drop_cnt_q + CNT_W'(1);

    full_d = (level_d == DepthL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gap_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      we_q        <= 1'b0;
      key_q       <= '0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
      boot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      we_q        <= we_d;
      key_q       <= key_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
      boot_done_q <= boot_done_d;
    end
  end

  // Storage is not reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

  assign o_we       = we_q;
  assign o_key      = key_q;
  assign o_full     = full_q;
  assign o_level    = level_q;
  assign o_busy     = (state_q != StIdle) || !empty;
  assign o_ovf      = ovf_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_console_key_injector.sv
module tb_console_key_injector;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr, flush, consf;
  logic [7:0]  data;
  logic [63:0] mtime, min_time;
  logic        we, full, busy, ovf;
  logic [7:0]  key, drop;
  logic [4:0]  level;

  // Second instance with no inter-key gap
  logic        z_wr, z_flush, z_consf;
  logic [7:0]  z_data;
  logic [63:0] z_mtime, z_min_time;
  logic        z_we, z_full, z_busy, z_ovf;
  logic [7:0]  z_key, z_drop;
  logic [4:0]  z_level;

  int n_vec = 0;
  int n_err = 0;

  console_key_injector #(.DEPTH(16), .GAP_CYCLES(64), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_wr(wr), .i_data(data), .i_flush(flush),
    .i_consf_en(consf), .i_mtime(mtime), .i_min_time(min_time),
    .o_we(we), .o_key(key), .o_full(full), .o_level(level), .o_busy(busy),
    .o_ovf(ovf), .o_drop_cnt(drop)
  );

  console_key_injector #(.DEPTH(16), .GAP_CYCLES(0), .CNT_W(8)) dut_gap0 (
    .clk(clk), .rst(rst), .i_wr(z_wr), .i_data(z_data), .i_flush(z_flush),
    .i_consf_en(z_consf), .i_mtime(z_mtime), .i_min_time(z_min_time),
    .o_we(z_we), .o_key(z_key), .o_full(z_full), .o_level(z_level), .o_busy(z_busy),
    .o_ovf(z_ovf), .o_drop_cnt(z_drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until the selected instance strobes; n counts edges taken.
  task automatic wait_we(input bit sel, input int max, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < max && !seen) begin
      step();
      n++;
      if ((sel ? z_we : we) === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", we); end
    n_vec++; if (key !== 8'h00) begin n_err++; $display("FAIL rst_key: got %h want 00", key); end
    n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
    n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL rst_full: got %b want 0", full); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    n_vec++; if (drop !== 8'd0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", drop); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (z_level !== 5'd0 || z_we !== 1'b0) begin
      n_err++; $display("FAIL rst_gap0: got level=%0d we=%b want 0 0", z_level, z_we);
    end
    rst = 1'b0;
  endtask

  task automatic test_boot_gating();
    int n;
    bit seen;
    logic [7:0] exp_keys [3];
    exp_keys[0] = 8'h6C; exp_keys[1] = 8'h73; exp_keys[2] = 8'h0A;
    min_time = 64'd100;
    mtime = 64'd0;
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin data = exp_keys[i]; step(); end
    wr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); if (we === 1'b1) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL boot_gated_we: got strobe want none"); end
    n_vec++; if (level !== 5'd3) begin n_err++; $display("FAIL boot_level: got %0d want 3", level); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL boot_busy: got %b want 1", busy); end
    mtime = 64'd99;
    step();
    mtime = 64'd100;
    step();
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL boot_edge_we: got %b want 0", we); end
    for (int i = 0; i < 3; i++) begin
      wait_we(1'b0, 200, n, seen);
      n_vec++; if (!seen || key !== exp_keys[i] || n != (i == 0 ? 3 : 67)) begin
        n_err++;
        $display("FAIL boot_key%0d: got seen=%b key=%h after %0d want key=%h after %0d",
                 i, seen, key, n, exp_keys[i], (i == 0 ? 3 : 67));
      end
    end
    step();
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL boot_strobe_width: got %b want 0", we); end
    for (int i = 0; i < 70; i++) step();
    n_vec++; if (level !== 5'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL boot_drained: got level=%0d busy=%b want 0 0", level, busy);
    end
  endtask

  task automatic test_backpressure();
    bit seen;
    consf = 1'b1;
    wr = 1'b1; data = 8'h41;
    step();
    wr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); if (we === 1'b1) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0 || busy !== 1'b1 || level !== 5'd1) begin
      n_err++; $display("FAIL bp_parked: got strobe=%b busy=%b level=%0d want 0 1 1", seen, busy, level);
    end
    consf = 1'b0;
    step();
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL bp_release_t: got %b want 0", we); end
    step();
    n_vec++; if (we !== 1'b1 || key !== 8'h41) begin
      n_err++; $display("FAIL bp_strobe: got we=%b key=%h want 1 41", we, key);
    end
    for (int i = 0; i < 70; i++) step();
  endtask

  task automatic test_overflow();
    int n;
    bit seen;
    mtime = 64'd0;
    rst = 1'b1; step(); rst = 1'b0;
    wr = 1'b1;
    for (int i = 0; i < 18; i++) begin data = 8'(i); step(); end
    wr = 1'b0;
    n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b want 1", full); end
    n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d want 16", level); end
    n_vec++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    n_vec++; if (drop !== 8'd2) begin n_err++; $display("FAIL ovf_drop: got %0d want 2", drop); end
    mtime = 64'd100;
    step(); step(); step();
    wr = 1'b1; data = 8'h55;   // lands in the SEND cycle
    step();
    wr = 1'b0;
    n_vec++; if (we !== 1'b1 || key !== 8'h00) begin
      n_err++; $display("FAIL fullpop_strobe: got we=%b key=%h want 1 00", we, key);
    end
    n_vec++; if (drop !== 8'd3 || level !== 5'd15 || full !== 1'b0) begin
      n_err++; $display("FAIL fullpop_drop: got drop=%0d level=%0d full=%b want 3 15 0", drop, level, full);
    end
    for (int i = 1; i < 16; i++) begin
      wait_we(1'b0, 200, n, seen);
      n_vec++; if (!seen || key !== 8'(i) || n != 67) begin
        n_err++; $display("FAIL ovf_drain%0d: got seen=%b key=%h after %0d want key=%h after 67",
                          i, seen, key, n, 8'(i));
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 75; i++) begin step(); if (we === 1'b1) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0 || level !== 5'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL ovf_tail: got strobe=%b level=%0d busy=%b want 0 0 0", seen, level, busy);
    end
  endtask

  task automatic test_flush();
    bit seen;
    wr = 1'b1;
    for (int i = 0; i < 4; i++) begin data = 8'hA0 + 8'(i); step(); end
    n_vec++; if (we !== 1'b1 || key !== 8'hA0) begin
      n_err++; $display("FAIL flush_first: got we=%b key=%h want 1 a0", we, key);
    end
    data = 8'hA4; step();
    wr = 1'b0;
    n_vec++; if (level !== 5'd4) begin n_err++; $display("FAIL flush_prelevel: got %0d want 4", level); end
    step(); step(); step();
    flush = 1'b1; wr = 1'b1; data = 8'hEE;
    step();
    flush = 1'b0; wr = 1'b0;
    n_vec++; if (level !== 5'd0 || busy !== 1'b0 || we !== 1'b0 || full !== 1'b0) begin
      n_err++; $display("FAIL flush_state: got level=%0d busy=%b we=%b full=%b want 0 0 0 0",
                        level, busy, we, full);
    end
    n_vec++; if (drop !== 8'd3 || ovf !== 1'b1) begin
      n_err++; $display("FAIL flush_keep: got drop=%0d ovf=%b want 3 1", drop, ovf);
    end
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin step(); if (we === 1'b1) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0 || level !== 5'd0) begin
      n_err++; $display("FAIL flush_quiet: got strobe=%b level=%0d want 0 0", seen, level);
    end
  endtask

  task automatic test_reset_mid_send();
    int n;
    bit seen;
    wr = 1'b1; data = 8'h77;
    step();
    wr = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++; if (we !== 1'b0 || key !== 8'h00 || level !== 5'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rms_out: got we=%b key=%h level=%0d busy=%b want 0 00 0 0",
                        we, key, level, busy);
    end
    n_vec++; if (ovf !== 1'b0 || drop !== 8'd0 || full !== 1'b0) begin
      n_err++; $display("FAIL rms_stat: got ovf=%b drop=%0d full=%b want 0 0 0", ovf, drop, full);
    end
    mtime = 64'd50;
    wr = 1'b1; data = 8'h78;
    step();
    wr = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); if (we === 1'b1) seen = 1'b1; end
    n_vec++; if (seen !== 1'b0 || level !== 5'd1) begin
      n_err++; $display("FAIL rms_regated: got strobe=%b level=%0d want 0 1", seen, level);
    end
    mtime = 64'd100;
    step();
    wait_we(1'b0, 10, n, seen);
    n_vec++; if (!seen || key !== 8'h78 || n != 3) begin
      n_err++; $display("FAIL rms_reboot: got seen=%b key=%h after %0d want 78 after 3", seen, key, n);
    end
    for (int i = 0; i < 70; i++) step();
  endtask

  task automatic test_gap0();
    int n;
    bit seen;
    logic [7:0] exp_keys [3];
    exp_keys[0] = 8'h31; exp_keys[1] = 8'h32; exp_keys[2] = 8'h33;
    z_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin z_data = exp_keys[i]; step(); end
    z_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_we(1'b1, 10, n, seen);
      n_vec++; if (!seen || z_key !== exp_keys[i] || n != (i == 0 ? 1 : 3)) begin
        n_err++; $display("FAIL gap0_key%0d: got seen=%b key=%h after %0d want key=%h after %0d",
                          i, seen, z_key, n, exp_keys[i], (i == 0 ? 1 : 3));
      end
    end
    step(); step();
    n_vec++; if (z_level !== 5'd0 || z_busy !== 1'b0) begin
      n_err++; $display("FAIL gap0_idle: got level=%0d busy=%b want 0 0", z_level, z_busy);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; data = 8'h00; flush = 1'b0; consf = 1'b0;
    mtime = 64'd0; min_time = 64'd100;
    z_wr = 1'b0; z_data = 8'h00; z_flush = 1'b0; z_consf = 1'b0;
    z_mtime = 64'd0; z_min_time = 64'd0;
    test_reset();
    test_boot_gating();
    test_backpressure();
    test_overflow();
    test_flush();
    test_reset_mid_send();
    test_gap0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
